// File: rtl/packet_serializer.sv
// packet_serializer: frames {hdr, sync, payload} and shifts it MSB first
// on the bit strobe, then holds the line low for a gap before the next frame.
module packet_serializer #(
  parameter int GAP_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       i_CONFIG,
  input  logic       TX_MODE,
  input  logic       pkt_valid,
  input  logic [9:0] hdr,
  input  logic [9:0] payload,
  output logic       pkt_ready,
  output logic       dout,
  output logic       tx_active,
  output logic       pkt_sent
);

  localparam int PACKET_SIZE = 24;
  localparam logic [3:0] SYNC = 4'b1111;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [4:0] LAST_BIT = 5'(PACKET_SIZE - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e                   state_q, state_d;
  logic [PACKET_SIZE-1:0]   shift_reg_q, shift_reg_d;
  logic [4:0]               bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]            gap_cnt_q, gap_cnt_d;
  logic                     pkt_sent_q, pkt_sent_d;
  logic                     inhibit;

  assign inhibit = i_CONFIG | ~TX_MODE;

  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pkt_sent_d  = 1'b0;
    if (inhibit) begin
      state_d     = S_IDLE;
      shift_reg_d = '0;
      bit_cnt_d   = '0;
      gap_cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pkt_valid) begin
            shift_reg_d = {hdr, SYNC, payload};
            bit_cnt_d   = '0;
            state_d     = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (en) begin
            shift_reg_d = {shift_reg_q[PACKET_SIZE-2:0], 1'b0};
            bit_cnt_d   = bit_cnt_q + 5'd1;
            if (bit_cnt_q == LAST_BIT) begin
              // the register is all zeros now, so the gap line is low
              pkt_sent_d = 1'b1;
              bit_cnt_d  = '0;
              gap_cnt_d  = '0;
              state_d    = (GAP_BITS == 0) ? S_IDLE : S_GAP;
            end
          end
        end
        S_GAP: begin
          if (en) begin
            if (gap_cnt_q == GAP_LAST) begin
              gap_cnt_d = '0;
              state_d   = S_IDLE;
            end else begin
              gap_cnt_d = gap_cnt_q + GW'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_reg_q <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      pkt_sent_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pkt_sent_q  <= pkt_sent_d;
    end
  end

  assign dout      = shift_reg_q[PACKET_SIZE-1];
  assign tx_active = (state_q == S_SHIFT);
  assign pkt_sent  = pkt_sent_q;
  assign pkt_ready = (state_q == S_IDLE) & ~inhibit;

endmodule

// File: tb/tb_packet_serializer.sv
// tb_packet_serializer: vector table, corner sequences and random traffic,
// all checked cycle by cycle against a queue-of-line-bits reference model.
module tb_packet_serializer;

  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst, en, i_CONFIG, TX_MODE, pkt_valid;
  logic [9:0] hdr, payload;
  logic       pkt_ready, dout, tx_active, pkt_sent;

  always #5 clk = ~clk;

  packet_serializer #(.GAP_BITS(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .i_CONFIG  (i_CONFIG),
    .TX_MODE   (TX_MODE),
    .pkt_valid (pkt_valid),
    .hdr       (hdr),
    .payload   (payload),
    .pkt_ready (pkt_ready),
    .dout      (dout),
    .tx_active (tx_active),
    .pkt_sent  (pkt_sent)
  );

  // receiving shift buffer paced by the same strobe
  logic [23:0] rx = '0;
  always @(posedge clk) if (en) rx <= {rx[22:0], dout};

  int checks = 0;
  int errors = 0;

  bit mq[$];
  int m_left = 0;
  bit m_sent = 1'b0;

  int shift_strobes, gap_strobes, gap_cycles, sent_seen;
  logic [23:0] rx_snap;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  p;
    int          per;
    logic [23:0] exp;
  } vec_t;

  vec_t vt[6];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit inh();
    return i_CONFIG | ~TX_MODE;
  endfunction

  task automatic model_step();
    bit s;
    s = 1'b0;
    if (rst || inh()) begin
      mq.delete();
      m_left = 0;
    end else if (mq.size() == 0) begin
      if (pkt_valid) begin
        logic [23:0] f;
        f = {hdr, 4'b1111, payload};
        for (int i = 23; i >= 0; i--) mq.push_back(f[i]);
        repeat (GAP) mq.push_back(1'b0);
        m_left = 24;
      end
    end else if (en) begin
      void'(mq.pop_front());
      if (m_left > 0) begin
        m_left--;
        s = (m_left == 0);
      end
    end
    m_sent = s;
  endtask

  task automatic tick();
    bit st_shift, st_gap;
    #1;
    chk("pkt_ready", pkt_ready, (mq.size() == 0 && !inh()) ? 1 : 0);
    st_shift = en && tx_active && !rst && !inh();
    st_gap   = !tx_active && !pkt_ready && !rst && !inh();
    @(posedge clk);
    model_step();
    #1;
    chk("dout", dout, (mq.size() > 0) ? mq[0] : 1'b0);
    chk("tx_active", tx_active, (m_left > 0) ? 1 : 0);
    chk("pkt_sent", pkt_sent, m_sent);
    if (st_shift) shift_strobes++;
    if (st_gap) gap_cycles++;
    if (st_gap && en) gap_strobes++;
    if (pkt_sent) begin
      sent_seen++;
      rx_snap = rx;
    end
  endtask

  task automatic clr_cnt();
    shift_strobes = 0;
    gap_strobes   = 0;
    gap_cycles    = 0;
    sent_seen     = 0;
  endtask

  task automatic set_idle();
    rst = 0; en = 0; i_CONFIG = 0; TX_MODE = 1;
    pkt_valid = 0; hdr = '0; payload = '0;
  endtask

  task automatic run_vec(vec_t v);
    bit done;
    done = 1'b0;
    clr_cnt();
    hdr = v.h; payload = v.p; pkt_valid = 1; en = 0;
    tick();
    pkt_valid = 0; hdr = ~v.h; payload = ~v.p;
    for (int c = 0; c < 600 && !done; c++) begin
      en = ((c % v.per) == 0);
      tick();
      done = (sent_seen > 0) && pkt_ready;
    end
    en = 0;
    chk("vec_done", done, 1);
    chk("frame", rx_snap, v.exp);
    chk("rx_sync", rx_snap[13:10], 4'hF);
    chk("shift_strobes", shift_strobes, 24);
    chk("sent_once", sent_seen, 1);
    chk("gap_strobes", gap_strobes, GAP);
    chk("gap_cycles", gap_cycles, GAP * v.per);
  endtask

  initial begin
    vt[0] = '{10'h2AA, 10'h155, 1, 24'hAABD55};
    vt[1] = '{10'h2AA, 10'h155, 3, 24'hAABD55};
    vt[2] = '{10'h3FF, 10'h3FF, 1, 24'hFFFFFF};
    vt[3] = '{10'h000, 10'h000, 2, 24'h003C00};
    vt[4] = '{10'h200, 10'h001, 1, 24'h803C01};
    vt[5] = '{10'h155, 10'h2AA, 4, 24'h557EAA};

    set_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    tick();
    chk("rst_dout", dout, 0);
    chk("rst_tx_active", tx_active, 0);
    chk("rst_pkt_sent", pkt_sent, 0);
    rst = 0;
    #1;
    chk("rst_pkt_ready", pkt_ready, 1);
    tick();

    foreach (vt[i]) run_vec(vt[i]);

    // abort by config mode after 10 strobes
    clr_cnt();
    hdr = 10'h3C3; payload = 10'h0F0; pkt_valid = 1;
    tick();
    pkt_valid = 0; en = 1;
    repeat (10) tick();
    i_CONFIG = 1;
    tick();
    chk("abort_tx_active", tx_active, 0);
    chk("abort_dout", dout, 0);
    pkt_valid = 1;
    tick();
    chk("abort_no_accept", tx_active, 0);
    i_CONFIG = 0; pkt_valid = 0;
    repeat (3) tick();
    chk("abort_no_sent", sent_seen, 0);
    en = 0;
    run_vec(vt[4]);

    // inhibit on the final strobe wins over pkt_sent
    clr_cnt();
    hdr = 10'h111; payload = 10'h222; pkt_valid = 1;
    tick();
    pkt_valid = 0; en = 1;
    repeat (23) tick();
    TX_MODE = 0;
    tick();
    chk("last_abort_sent", pkt_sent, 0);
    chk("last_abort_tx", tx_active, 0);
    TX_MODE = 1; en = 0;
    tick();
    chk("last_abort_none", sent_seen, 0);

    // back-to-back with pkt_valid held high
    begin
      bit done;
      done = 1'b0;
      clr_cnt();
      hdr = 10'h0AB; payload = 10'h3CD; pkt_valid = 1; en = 1;
      for (int c = 0; c < 300 && !done; c++) begin
        tick();
        done = (sent_seen == 2);
      end
      chk("b2b_done", done, 1);
      chk("b2b_shift", shift_strobes, 48);
      chk("b2b_gap", gap_strobes, GAP);
      pkt_valid = 0;
      done = 1'b0;
      for (int c = 0; c < 50 && !done; c++) begin
        tick();
        done = pkt_ready;
      end
      chk("b2b_drain", done, 1);
      en = 0;
    end

    // reset at bit 12
    hdr = 10'h2F0; payload = 10'h00F; pkt_valid = 1;
    tick();
    pkt_valid = 0; en = 1;
    repeat (12) tick();
    rst = 1;
    tick();
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_tx", tx_active, 0);
    chk("mid_rst_sent", pkt_sent, 0);
    rst = 0;
    #1;
    chk("mid_rst_ready", pkt_ready, 1);
    tick();
    en = 0;
    run_vec(vt[0]);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      en        = $urandom_range(0, 1) == 1;
      pkt_valid = $urandom_range(0, 3) == 0;
      hdr       = 10'($urandom);
      payload   = 10'($urandom);
      i_CONFIG  = $urandom_range(0, 59) == 0;
      TX_MODE   = $urandom_range(0, 79) != 0;
      rst       = $urandom_range(0, 299) == 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_serializer.md
PACKET_SERIALIZER -- requirements
Module: packet_serializer

Interface
REQ-001 SHALL have parameter GAP_BITS, default 4, meaning the number of en strobes of forced-0 line between packets (0 allowed).
REQ-002 SHALL fix PACKET_SIZE = 24 bits and SYNC = 4'b1111 at packet bits [13:10] as internal constants.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1, bit strobe; the same strobe that paces the receiving shift buffer.
REQ-006 SHALL have port i_CONFIG, input, 1, config mode; when high, transmission is inhibited.
REQ-007 SHALL have port TX_MODE, input, 1, transmit enable; when low, transmission is inhibited.
REQ-008 SHALL have port pkt_valid, input, 1, request to send the presented fields.
REQ-009 SHALL have port hdr, input, 10, field placed in packet bits [23:14].
REQ-010 SHALL have port payload, input, 10, field placed in packet bits [9:0].
REQ-011 SHALL have port pkt_ready, output, 1, high only in IDLE with TX_MODE=1 and i_CONFIG=0.
REQ-012 SHALL have port dout, output, 1, serial line, registered, MSB first.
REQ-013 SHALL have port tx_active, output, 1, high while in SHIFT.
REQ-014 SHALL have port pkt_sent, output, 1, one-cycle pulse after the last bit is shifted.

Function
REQ-015 SHALL implement the states IDLE, SHIFT and GAP.
REQ-016 SHALL treat the inhibit condition as (i_CONFIG | !TX_MODE).
REQ-017 SHALL, in IDLE, accept a packet on a cycle where pkt_valid & pkt_ready; next cycle: shift_reg = {hdr, 4'b1111, payload}, bit_cnt = 0, state = SHIFT.
REQ-018 SHALL drive dout = shift_reg[23] continuously, so bit 23 appears the cycle after acceptance.
REQ-019 SHALL, in SHIFT, on each cycle with en=1, shift shift_reg left with a 0 fill and increment bit_cnt (5-bit).
REQ-020 SHALL hold shift_reg and bit_cnt in SHIFT when en=0.
REQ-021 SHALL make the transition SHIFT->GAP on the en cycle where bit_cnt == 23, with pkt_sent=1 in the following cycle only; if GAP_BITS == 0, go SHIFT->IDLE directly instead.
REQ-022 SHALL hold dout = 0 in GAP, count en strobes, and go to IDLE after GAP_BITS strobes.
REQ-023 SHALL keep pkt_ready = 0 in SHIFT and GAP, so pkt_valid is ignored outside IDLE.
REQ-024 SHALL, on inhibit high in any state, go to IDLE next cycle with shift_reg = 0 and bit_cnt = 0; pkt_sent is not pulsed for an aborted packet.
REQ-025 SHALL treat inhibit high on the same cycle as pkt_valid as follows: packet not accepted (pkt_ready = 0).
REQ-026 SHALL treat inhibit on the same cycle as the final en as follows: abort wins and pkt_sent = 0.
REQ-027 SHALL latch hdr and payload only at acceptance; later input changes do not alter the frame in flight.
REQ-028 SHALL produce a frame that, fed with the same en to the 24-bit receiving shift buffer, leaves the receiver register equal to {hdr, 4'b1111, payload} after 24 strobes.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, set state=IDLE, shift_reg=0, bit_cnt=0, gap_cnt=0, dout=0, tx_active=0, pkt_sent=0; pkt_ready then follows REQ-011.
REQ-030 SHALL give rst priority over all other inputs, including mid-SHIFT; after reset the partial frame is discarded.

Verification
REQ-031 SHALL cover the basic frame: TX_MODE=1, hdr=10'h2AA, payload=10'h155, pkt_valid pulse, en every cycle -> dout sequence equals 24'hAABD55 MSB first, pkt_sent once, then 4 zero bits, pkt_ready=1.
REQ-032 SHALL cover a sparse strobe: en every 3rd cycle -> each bit held 3 cycles, 24 strobes to pkt_sent, GAP lasts 12 cycles.
REQ-033 SHALL cover a mid-frame abort: i_CONFIG=1 after 10 strobes -> next cycle IDLE, dout=0, tx_active=0, no pkt_sent; a new packet is accepted afterward.
REQ-034 SHALL cover back-to-back requests: pkt_valid held high -> second accept occurs only after GAP ends, with exactly GAP_BITS zero bits between frames.
REQ-035 SHALL cover loopback: dout and en wired to the receiving shift buffer -> after 24 strobes its register = {hdr, 4'b1111, payload} and it flags sync.
REQ-036 SHALL cover reset mid-SHIFT: rst=1 for one cycle at bit 12 -> all outputs at reset values next cycle and pkt_ready=1.
